range_cam_ctrl: RTL

Sequencing controller for the dual-write-port range CAM (entry = {vld, min, max}, 2-cycle search-to-bitmap latency). Owns entry allocation, insert/delete, post-reset and on-demand flush of the uninitialised CAM array, and reduction of the search bitmap to a lowest-index hit. Sits between the scheduler's classification logic and one CAM instance.

---
 rtl/range_cam_ctrl_pkg.sv | 23 ++
 rtl/range_cam_prienc.sv | 24 ++
 rtl/range_cam_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/range_cam_ctrl_pkg.sv
// range_cam_pkg: shared types for the range CAM controller.
// Holds the controller state enum, the CAM entry layout and the CAM search latency.
package range_cam_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Search-to-bitmap latency of the CAM macro, in cycles.
  localparam int CAM_LAT = 2;

  // Default range key width; the controller packs {vld, min, max} for any width.
  localparam int ENT_RANG_W = 8;

  typedef struct packed {
    logic                  vld;
    logic [ENT_RANG_W-1:0] min;
    logic [ENT_RANG_W-1:0] max;
  } cam_entry_t;

endpackage

// File: rtl/range_cam_prienc.sv
// range_cam_prienc: lowest-index priority encoder with an any-bit flag.
// Used for both free-entry selection and search bitmap reduction.
module range_cam_prienc #(
  parameter int W  = 16,
  parameter int IW = 4
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan high to low so the last assignment is the lowest set bit.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = W-1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/range_cam_ctrl.sv
// range_cam_ctrl: sequencing controller for a dual-write-port range CAM.
// Allocation, insert/delete, init/flush sweep of the array, and lowest-index
// reduction of the search bitmap. Optional macro RANGE_CAM_CTRL_STATS_EN adds
// saturating hit/miss counters.
module range_cam_ctrl
  import range_cam_pkg::*;
#(
  parameter int NUMADDR = 1024,
  parameter int BITADDR = 10,
  parameter int BITRANG = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  output logic                 busy,
  input  logic                 ins_vld,
  output logic                 ins_rdy,
  input  logic [BITRANG-1:0]   ins_min,
  input  logic [BITRANG-1:0]   ins_max,
  output logic [BITADDR-1:0]   ins_adr,
  output logic                 ins_err,
  input  logic                 del_vld,
  input  logic [BITADDR-1:0]   del_adr,
  output logic                 del_err,
  input  logic                 lkp_vld,
  output logic                 lkp_rdy,
  input  logic [BITRANG-1:0]   lkp_key,
  output logic                 rsp_vld,
  output logic                 rsp_hit,
  output logic [BITADDR-1:0]   rsp_adr,
  output logic [BITADDR:0]     occ,
  output logic                 cam_write_0,
  output logic [BITADDR-1:0]   cam_wr_adr_0,
  output logic [2*BITRANG:0]   cam_wr_din_0,
  output logic                 cam_write_1,
  output logic [BITADDR-1:0]   cam_wr_adr_1,
  output logic [2*BITRANG:0]   cam_wr_din_1,
  output logic                 cam_search,
  output logic [BITRANG-1:0]   cam_sr_rng,
  input  logic [NUMADDR-1:0]   cam_sr_bmp
`ifdef RANGE_CAM_CTRL_STATS_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
`endif
);

  localparam int STAGES = CAM_LAT;
  localparam logic [BITADDR-1:0] PTR_LAST = BITADDR'(NUMADDR-2);

  state_e               state, state_nxt;
  logic [BITADDR-1:0]   ptr;
  logic [NUMADDR-1:0]   alloc, alloc_nxt;
  logic                 free_any, bmp_any;
  logic [BITADDR-1:0]   free_idx, bmp_idx;
  logic                 sweep, ins_fire, ins_bad, ins_ok;
  logic                 del_fire, del_ok, lkp_fire, flush_go, rsp_hit_d;
  logic [STAGES:1]      vld_pipe, kill_pipe;

  range_cam_prienc #(.W(NUMADDR), .IW(BITADDR)) u_free (
    .vec (~alloc),
    .idx (free_idx),
    .any (free_any)
  );

  range_cam_prienc #(.W(NUMADDR), .IW(BITADDR)) u_bmp (
    .vec (cam_sr_bmp),
    .idx (bmp_idx),
    .any (bmp_any)
  );

  assign busy     = (state != ST_RUN);
  // Reset parks the FSM in INIT; keep the sweep strobes quiet until reset lifts.
  assign sweep    = busy && rst_n;
  assign ins_rdy  = (state == ST_RUN) && free_any;
  assign ins_adr  = free_idx;
  assign lkp_rdy  = !busy;
  assign ins_fire = ins_vld && ins_rdy;
  assign ins_bad  = ins_min > ins_max;
  assign ins_ok   = ins_fire && !ins_bad;
  assign del_fire = del_vld && !busy;
  // Only free what is allocated, so port 1 can never clobber a same-cycle insert.
  assign del_ok   = del_fire && alloc[del_adr];
  assign lkp_fire = lkp_vld && lkp_rdy;
  assign flush_go = flush && !busy;

  // Port 0: sweep even entries, else inserts. Port 1: sweep odd entries, else deletes.
  assign cam_write_0  = sweep || ins_ok;
  assign cam_wr_adr_0 = busy ? ptr : free_idx;
  assign cam_wr_din_0 = busy ? '0 : {1'b1, ins_min, ins_max};
  assign cam_write_1  = sweep || del_ok;
  assign cam_wr_adr_1 = busy ? (ptr + BITADDR'(1)) : del_adr;
  assign cam_wr_din_1 = '0;
  assign cam_search   = lkp_fire;
  assign cam_sr_rng   = lkp_key;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  // Sweep runs until the last even pair is written; flush only honoured in RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT, ST_FLUSH: if (ptr == PTR_LAST) state_nxt = ST_RUN;
      ST_RUN:            if (flush) state_nxt = ST_FLUSH;
      default:           state_nxt = ST_INIT;
    endcase
  end

  // Sweep pointer steps by two and wraps back to 0 as the sweep ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= '0;
    else if (busy) ptr <= ptr + BITADDR'(2);
  end

  // Next allocation map: insert claims the free slot, delete releases its slot.
  always_comb begin
    alloc_nxt = alloc;
    if (ins_ok) alloc_nxt[free_idx] = 1'b1;
    if (del_ok) alloc_nxt[del_adr]  = 1'b0;
  end

  // Allocation map and occupancy; flush wipes both regardless of same-cycle traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc <= '0;
      occ   <= '0;
    end else if (flush_go || busy) begin
      alloc <= '0;
      occ   <= '0;
    end else begin
      alloc <= alloc_nxt;
      occ   <= occ + (BITADDR+1)'(ins_ok) - (BITADDR+1)'(del_ok);
    end
  end

  // Error pulses, one cycle after the offending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_err <= 1'b0;
      del_err <= 1'b0;
    end else begin
      ins_err <= ins_fire && ins_bad;
      del_err <= del_fire && !alloc[del_adr];
    end
  end

  // Lookup tracking across the CAM latency; kill marks lookups caught by a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      kill_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], lkp_fire};
      kill_pipe <= {kill_pipe[STAGES-1:1], 1'b0} | {STAGES{flush_go}};
    end
  end

  assign rsp_hit_d = vld_pipe[STAGES] && bmp_any && !kill_pipe[STAGES] && !flush_go;

  // Registered response: lowest matching index, zero address on a miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld <= 1'b0;
      rsp_hit <= 1'b0;
      rsp_adr <= '0;
    end else begin
      rsp_vld <= vld_pipe[STAGES];
      rsp_hit <= rsp_hit_d;
      rsp_adr <= rsp_hit_d ? bmp_idx : '0;
    end
  end

`ifdef RANGE_CAM_CTRL_STATS_EN
  // Saturating response tally; a flush restarts it along with the table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (flush_go) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rsp_vld) begin
      if (rsp_hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      end else if (miss_cnt != '1) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
